// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and line-level constants shared by the serial transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic SERIAL_IDLE  = 1'b1;
    localparam logic SERIAL_START = 1'b0;
    localparam logic SERIAL_STOP  = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and
// raises Bit_Tick for one cycle on the last count. Clear restarts the period so
// every state of the transmitter begins with a full bit time.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Clear,
    output logic Bit_Tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] count;

    assign Bit_Tick = (count == CNT_LAST);

    // Bit-period counter: wraps on the tick, restarts on Clear
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (Clear || Bit_Tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter. One word per frame,
// sent LSB first between a start bit (0) and a stop bit (1); line idles high.
// Build option: define TX_PARITY_EN to insert an even-parity bit between the
// last data bit and the stop bit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, Tx_Ready=1, waiting for Tx_Valid
// START  | line low for one bit time
// DATA   | line = shifter[0], shift right once per bit time, SIZE bits
// PARITY | line = even parity of the accepted word (TX_PARITY_EN only)
// STOP   | line high for one bit time, then back to IDLE with Tx_Done
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int SIZE         = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [SIZE-1:0] Tx_Data,
    input  logic            Tx_Valid,
    output logic            Tx_Ready,
    output logic            Tx_Serial,
    output logic            Tx_Busy,
    output logic            Tx_Done
);

    localparam int BW = $clog2(SIZE) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    tx_state_t       state;
    tx_state_t       state_next;
    logic [SIZE-1:0] shifter;
    logic [SIZE-1:0] shifter_next;
    logic [BW-1:0]   bit_cnt;
    logic [BW-1:0]   bit_cnt_next;
    logic            serial_next;
    logic            done_next;
    logic            bit_tick;
    logic            baud_clear;
    logic            handshake;
`ifdef TX_PARITY_EN
    logic            parity_bit;
`endif

    assign Tx_Ready  = (state == IDLE);
    assign Tx_Busy   = (state != IDLE);
    assign handshake = Tx_Valid && Tx_Ready;

    // The bit period restarts whenever the FSM moves, and is held at zero in IDLE
    // so the start bit always gets a full bit time after the handshake.
    assign baud_clear = (state_next != state) || (state == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Clear    (baud_clear),
        .Bit_Tick (bit_tick)
    );

    // Next-state, shifter, bit counter and registered-output decode
    always_comb begin
        state_next   = state;
        shifter_next = shifter;
        bit_cnt_next = bit_cnt;
        done_next    = 1'b0;
        serial_next  = SERIAL_IDLE;

        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next   = START;
                    shifter_next = Tx_Data;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shifter_next = {1'b0, shifter[SIZE-1:1]};
                    bit_cnt_next = bit_cnt + BIT_ONE;
                    if (bit_cnt == BIT_LAST) begin
`ifdef TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The line is registered, so it is decoded from where the FSM is going
        // rather than where it is; this puts the start bit one cycle after the
        // handshake with no glitch path to the pin.
        case (state_next)
            IDLE:    serial_next = SERIAL_IDLE;
            START:   serial_next = SERIAL_START;
            DATA:    serial_next = shifter_next[0];
`ifdef TX_PARITY_EN
            PARITY:  serial_next = parity_bit;
`endif
            STOP:    serial_next = SERIAL_STOP;
            default: serial_next = SERIAL_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers; reset drives the line high immediately
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shifter   <= '0;
            bit_cnt   <= '0;
            Tx_Serial <= SERIAL_IDLE;
            Tx_Done   <= 1'b0;
        end else begin
            shifter   <= shifter_next;
            bit_cnt   <= bit_cnt_next;
            Tx_Serial <= serial_next;
            Tx_Done   <= done_next;
        end
    end

`ifdef TX_PARITY_EN
    // Even parity of the accepted word, frozen for the rest of the frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            parity_bit <= 1'b0;
        end else if (handshake) begin
            parity_bit <= ^Tx_Data;
        end
    end
`endif

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench for serial_frame_tx (SIZE=8, CLKS_PER_BIT=4).
// Stimulus pushes the expected frame for every accepted word; a monitor watches
// the serial line and pops/compares each frame bit by bit, including the
// Tx_Done pulse and the idle gap between back-to-back frames.
module tb_serial_frame_tx;

    localparam int SIZE = 8;
    localparam int CPB  = 4;
`ifdef TX_PARITY_EN
    localparam int NB = SIZE + 3;
`else
    localparam int NB = SIZE + 2;
`endif
    localparam int FRAME_CYC = NB * CPB;

    typedef struct {
        logic [10:0] bits;
        int          nb;
        int          gap;
    } frame_t;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic [SIZE-1:0] Tx_Data;
    logic            Tx_Valid;
    logic            Tx_Ready;
    logic            Tx_Serial;
    logic            Tx_Busy;
    logic            Tx_Done;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    always #5 Clk = ~Clk;

    serial_frame_tx #(
        .SIZE         (SIZE),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Tx_Data   (Tx_Data),
        .Tx_Valid  (Tx_Valid),
        .Tx_Ready  (Tx_Ready),
        .Tx_Serial (Tx_Serial),
        .Tx_Busy   (Tx_Busy),
        .Tx_Done   (Tx_Done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected frame: start 0, word LSB first, [hand-computed parity], stop 1.
    function automatic frame_t mk(input logic [7:0] w, input logic par, input int gap);
        frame_t f;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[i+1] = w[i];
        f.bits[9] = par;
`ifndef TX_PARITY_EN
        f.bits[9] = 1'b1;
`endif
        f.nb  = NB;
        f.gap = gap;
        return f;
    endfunction

    task automatic do_handshake(input logic [7:0] w);
        int n = 0;
        Tx_Data  = w;
        Tx_Valid = 1'b1;
        while (!Tx_Ready && n < 8 * FRAME_CYC) begin
            @(negedge Clk);
            n++;
        end
        check("handshake_ready", Tx_Ready, 1'b1);
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input int exp_lat);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 4 * FRAME_CYC) begin
            @(negedge Clk);
            n++;
            if (Tx_Done === 1'b1) seen = 1'b1;
        end
        check("done_seen", seen, 1'b1);
        if (seen && exp_lat > 0) check("done_latency", n, exp_lat);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Monitor: pops one expected frame per start bit and checks it cycle by cycle.
    initial begin : monitor
        frame_t cur;
        int     c        = 0;
        bit     in_frame = 1'b0;
        int     idle_run = 0;
        cur = mk(8'h00, 1'b0, -1);
        forever begin
            @(negedge Clk);
            if (Reset_n !== 1'b1) begin
                in_frame = 1'b0;
                c        = 0;
                idle_run = 0;
                exp_q.delete();
            end else begin
                if (!in_frame && Tx_Serial === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: start bit with no word accepted (t=%0t)", $time);
                        cur = mk(8'h00, 1'b0, -1);
                    end else begin
                        cur = exp_q.pop_front();
                        if (cur.gap >= 0) check("idle_gap", idle_run, cur.gap);
                    end
                    in_frame = 1'b1;
                    c        = 0;
                end
                if (in_frame) begin
                    if (c < cur.nb * CPB) begin
                        check("line_bit", Tx_Serial, cur.bits[c / CPB]);
                        check("busy_in_frame", Tx_Busy, 1'b1);
                        check("done_early", Tx_Done, 1'b0);
                        c++;
                    end else begin
                        check("done_pulse", Tx_Done, 1'b1);
                        check("done_line_idle", Tx_Serial, 1'b1);
                        check("done_not_busy", Tx_Busy, 1'b0);
                        in_frame = 1'b0;
                        idle_run = 1;
                    end
                end else begin
                    idle_run++;
                    check("idle_no_done", Tx_Done, 1'b0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        Reset_n  = 1'b0;
        Tx_Valid = 1'b0;
        Tx_Data  = '0;
        idle(3);
        check("rst_serial", Tx_Serial, 1'b1);
        check("rst_busy", Tx_Busy, 1'b0);
        check("rst_done", Tx_Done, 1'b0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
        check("ready_after_rst", Tx_Ready, 1'b1);

        // A5: 0,1,0,1,0,0,1,0,1,[0],1 ; Done at cycle FRAME_CYC+1
        exp_q.push_back(mk(8'hA5, 1'b0, -1));
        do_handshake(8'hA5);
        Tx_Valid = 1'b0;
        wait_done(FRAME_CYC + 1);
        idle(3);

        // Back-to-back with Tx_Valid held: exactly one idle cycle between frames
        exp_q.push_back(mk(8'h01, 1'b1, -1));
        exp_q.push_back(mk(8'hFF, 1'b0, 1));
        do_handshake(8'h01);
        Tx_Data = 8'hFF;
        do_handshake(8'hFF);
        Tx_Valid = 1'b0;
        wait_done(FRAME_CYC + 1);
        idle(3);

        // Tx_Data changes after acceptance must not affect the frame
        exp_q.push_back(mk(8'h3C, 1'b0, -1));
        do_handshake(8'h3C);
        Tx_Valid = 1'b0;
        Tx_Data  = 8'h00;
        wait_done(FRAME_CYC + 1);
        idle(3);

        // Valid while busy is ignored and not queued
        exp_q.push_back(mk(8'h5A, 1'b0, -1));
        do_handshake(8'h5A);
        Tx_Valid = 1'b0;
        idle(10);
        Tx_Data  = 8'hC3;
        Tx_Valid = 1'b1;
        #1;
        check("busy_not_ready", Tx_Ready, 1'b0);
        check("busy_flag", Tx_Busy, 1'b1);
        @(posedge Clk);
        #1 Tx_Valid = 1'b0;
        wait_done(-1);
        idle(2 * FRAME_CYC);

        // Reset in the middle of DATA (word 00 keeps the line low there)
        exp_q.push_back(mk(8'h00, 1'b0, -1));
        do_handshake(8'h00);
        Tx_Valid = 1'b0;
        repeat (14) @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        check("midframe_rst_serial", Tx_Serial, 1'b1);
        check("midframe_rst_busy", Tx_Busy, 1'b0);
        check("midframe_rst_done", Tx_Done, 1'b0);
        idle(2);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        #1;
        check("midframe_rst_ready", Tx_Ready, 1'b1);
        idle(3);

        // 07: parity bit 1 before the stop bit when parity is built in
        exp_q.push_back(mk(8'h07, 1'b1, -1));
        do_handshake(8'h07);
        Tx_Valid = 1'b0;
        wait_done(FRAME_CYC + 1);
        idle(5);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
